// File: rtl/iob2axi_wr_burst.sv
// iob2axi_wr_burst: splits a client write stream of `total` words starting at
// `base_addr` into AXI-style bursts of at most MAX_LEN beats, asks an external
// AXI writer to issue each burst, and passes the client beats straight through
// to the writer's native port.
// Optional feature: define IOB2AXI_WR_BURST_4K_EN to stop bursts crossing 4 KB.

`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif

module iob2axi_wr_burst #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic [CNT_W-1:0]       total,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    input  logic                   in_valid,
    input  logic [DATA_W-1:0]      in_wdata,
    input  logic [DATA_W/8-1:0]    in_wstrb,
    output logic                   in_ready,
    output logic                   run,
    output logic [`AXI_LEN_W-1:0]  length,
    input  logic                   wr_ready,
    input  logic                   wr_error,
    output logic                   s_valid,
    output logic [ADDR_W-1:0]      s_addr,
    output logic [DATA_W-1:0]      s_wdata,
    output logic [DATA_W/8-1:0]    s_wstrb,
    input  logic                   s_ready
);

    localparam int B   = DATA_W / 8;
    localparam int BSH = $clog2(B);
    // Beat-count width: wide enough for rem and for a full 4 KB page of bytes.
    localparam int NW  = (CNT_W > 13) ? CNT_W : 13;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_STREAM,
        ST_WAIT_B,
        ST_FIN
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [CNT_W-1:0]        rem_q, rem_d;
    logic [NW-1:0]           burst_n_q, burst_n_d;
    logic [NW-1:0]           beat_cnt_q, beat_cnt_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic                    run_q, run_d;
    logic [`AXI_LEN_W-1:0]   length_q, length_d;
    logic [ADDR_W-1:0]       s_addr_q, s_addr_d;

    logic [NW-1:0]           n_s;
    logic [NW-1:0]           n_m1_s;
    logic                    streaming_s;
    logic                    beat_s;
`ifdef IOB2AXI_WR_BURST_4K_EN
    logic [NW-1:0]           room_s;
`endif

    assign streaming_s = (state_q == ST_STREAM);
    // The data path is a pure pass-through so the writer sees client beats with no added latency.
    assign s_valid  = streaming_s & in_valid;
    assign in_ready = streaming_s & s_ready;
    assign s_wdata  = in_wdata;
    assign s_wstrb  = in_wstrb;
    assign beat_s   = s_valid & s_ready;

    assign busy   = busy_q;
    assign done   = done_q;
    assign error  = error_q;
    assign run    = run_q;
    assign length = length_q;
    assign s_addr = s_addr_q;

    // Size of the next burst: remaining words capped at MAX_LEN (and at the 4 KB page end if enabled).
    always_comb begin
        n_s = NW'(rem_q);
        if (n_s > NW'(MAX_LEN)) begin
            n_s = NW'(MAX_LEN);
        end else begin
            n_s = n_s;
        end
`ifdef IOB2AXI_WR_BURST_4K_EN
        room_s = (NW'(4096) - NW'(addr_q[11:0])) >> BSH;
        if (n_s > room_s) begin
            n_s = room_s;
        end else begin
            n_s = n_s;
        end
`endif
        n_m1_s = n_s - NW'(1);
    end

    // Next-state and next-output computation for the burst sequencer.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        burst_n_d  = burst_n_q;
        beat_cnt_d = beat_cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = error_q;
        run_d      = 1'b0;
        length_d   = length_q;
        s_addr_d   = s_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !busy_q) begin
                    addr_d  = base_addr;
                    rem_d   = total;
                    busy_d  = 1'b1;
                    error_d = 1'b0;
                    if (total == {CNT_W{1'b0}}) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // run is registered, so s_addr/length are registered alongside it to line up.
                if (wr_ready) begin
                    run_d      = 1'b1;
                    s_addr_d   = addr_q;
                    length_d   = n_m1_s[`AXI_LEN_W-1:0];
                    burst_n_d  = n_s;
                    beat_cnt_d = {NW{1'b0}};
                    state_d    = ST_STREAM;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_STREAM: begin
                if (beat_s) begin
                    if (beat_cnt_q == burst_n_q - NW'(1)) begin
                        addr_d  = addr_q + (ADDR_W'(burst_n_q) << BSH);
                        rem_d   = rem_q - CNT_W'(burst_n_q);
                        state_d = ST_WAIT_B;
                    end else begin
                        beat_cnt_d = beat_cnt_q + NW'(1);
                    end
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_WAIT_B: begin
                if (wr_ready) begin
                    if (wr_error) begin
                        error_d = 1'b1;
                        state_d = ST_FIN;
                    end else if (rem_q != {CNT_W{1'b0}}) begin
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_FIN;
                    end
                end else begin
                    state_d = ST_WAIT_B;
                end
            end
            ST_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered-output flops with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= {ADDR_W{1'b0}};
            rem_q      <= {CNT_W{1'b0}};
            burst_n_q  <= {NW{1'b0}};
            beat_cnt_q <= {NW{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            run_q      <= 1'b0;
            length_q   <= {`AXI_LEN_W{1'b0}};
            s_addr_q   <= {ADDR_W{1'b0}};
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            burst_n_q  <= burst_n_d;
            beat_cnt_q <= beat_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            run_q      <= run_d;
            length_q   <= length_d;
            s_addr_q   <= s_addr_d;
        end
    end

endmodule

// File: tb/tb_iob2axi_wr_burst.sv
// Testbench for iob2axi_wr_burst (DATA_W=32, MAX_LEN=16). A reactive writer/client
// process drives the handshakes; a burst-splitting reference model predicts runs.

`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif

module tb_iob2axi_wr_burst;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic [31:0]           base_addr = 32'd0;
    logic [15:0]           total = 16'd0;
    logic                  busy, done, error;
    logic                  in_valid = 1'b0;
    logic [31:0]           in_wdata = 32'd0;
    logic [3:0]            in_wstrb = 4'd0;
    logic                  in_ready;
    logic                  run;
    logic [`AXI_LEN_W-1:0] length;
    logic                  wr_ready = 1'b1;
    logic                  wr_error = 1'b0;
    logic                  s_valid;
    logic [31:0]           s_addr;
    logic [31:0]           s_wdata;
    logic [3:0]            s_wstrb;
    logic                  s_ready = 1'b0;

    iob2axi_wr_burst #(.ADDR_W(32), .DATA_W(32), .MAX_LEN(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .total(total),
        .busy(busy), .done(done), .error(error),
        .in_valid(in_valid), .in_wdata(in_wdata), .in_wstrb(in_wstrb), .in_ready(in_ready),
        .run(run), .length(length), .wr_ready(wr_ready), .wr_error(wr_error),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_ready(s_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // client data and observed traffic
    logic [31:0] cli_data [0:255];
    logic [3:0]  cli_strb [0:255];
    int          cli_idx = 0;
    int          cli_tot = 0;
    bit          cli_en = 1'b0;
    bit          cli_always = 1'b0;
    logic [31:0] run_addr_q [$];
    int          run_len_q [$];
    int          beats_seen = 0;
    int          done_cnt = 0;

    // writer model
    int          w_state = 0;   // 0 idle, 1 data, 2 response
    int          w_beats = 0;
    int          w_delay = 0;
    int          burst_no = 0;
    int          err_at_burst = -1;

    // reference expectations
    logic [31:0] exp_addr_q [$];
    int          exp_len_q [$];
    int          exp_beats = 0;
    bit          exp_err = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: carve total words into bursts from the stated size rules.
    task automatic model(input logic [31:0] base, input int tot, input int err_burst);
        int unsigned a;
        int rem, n, idx;
        a = base; rem = tot; idx = 0;
        exp_addr_q.delete(); exp_len_q.delete(); exp_beats = 0; exp_err = 1'b0;
        while (rem > 0) begin
            n = (rem < 16) ? rem : 16;
`ifdef IOB2AXI_WR_BURST_4K_EN
            if (n > (4096 - (a % 4096)) / 4) n = (4096 - (a % 4096)) / 4;
`endif
            exp_addr_q.push_back(a);
            exp_len_q.push_back(n - 1);
            exp_beats += n;
            a += n * 4;
            rem -= n;
            if (idx == err_burst) begin
                exp_err = 1'b1;
                break;
            end
            idx++;
        end
    endtask

    // Reactive writer + client: drive at negedge, observe handshakes 1ns later.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                w_state = 0; wr_ready = 1'b1; wr_error = 1'b0; s_ready = 1'b0; in_valid = 1'b0;
            end else begin
                if (w_state == 2) begin
                    if (w_delay == 0) begin
                        wr_ready = 1'b1;
                        wr_error = (burst_no - 1 == err_at_burst);
                        w_state = 0;
                    end else begin
                        w_delay--;
                    end
                end
                if (run) begin
                    run_addr_q.push_back(s_addr);
                    run_len_q.push_back(int'(length));
                    w_beats = int'(length) + 1;
                    w_state = 1;
                    wr_ready = 1'b0;
                    wr_error = 1'b0;
                    burst_no++;
                end
                s_ready  = (w_state == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
                in_valid = cli_always || (cli_en && ($urandom_range(0, 3) != 0));
                in_wdata = cli_data[cli_idx & 255];
                in_wstrb = cli_strb[cli_idx & 255];
                #1;
                if (s_valid && s_ready) begin
                    if (cli_idx >= cli_tot) chk("extra_beat", 64'(cli_idx), 64'(cli_tot));
                    chk("beat_data", 64'(s_wdata), 64'(cli_data[cli_idx & 255]));
                    chk("beat_strb", 64'(s_wstrb), 64'(cli_strb[cli_idx & 255]));
                    chk("beat_in_ready", 64'(in_ready), 64'd1);
                    cli_idx++;
                    beats_seen++;
                    w_beats--;
                    if (w_beats <= 0) begin
                        w_state = 2;
                        w_delay = $urandom_range(0, 3);
                    end
                end
                if (done) done_cnt++;
            end
        end
    end

    task automatic prep(input int tot, input int err_burst);
        for (int i = 0; i < 256; i++) begin
            cli_data[i] = $urandom;
            cli_strb[i] = 4'($urandom);
        end
        cli_idx = 0; cli_tot = tot; beats_seen = 0; done_cnt = 0;
        run_addr_q.delete(); run_len_q.delete();
        burst_no = 0; err_at_burst = err_burst; cli_en = 1'b1;
    endtask

    task automatic xfer(input logic [31:0] base, input int tot, input int err_burst, input bit poke);
        bit got;
        int done_cyc;
        int nchk;
        prep(tot, err_burst);
        model(base, tot, err_burst);
        got = 1'b0; done_cyc = 0;
        @(negedge clk);
        start = 1'b1; base_addr = base; total = 16'(tot);
        for (int cyc = 1; cyc <= 3000; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin start = 1'b0; base_addr = 32'h0000_0500; total = 16'd3; end
            if (poke && cyc == 6) start = 1'b1;
            if (poke && cyc == 7) start = 1'b0;
            #2;
            if (cyc == 1) chk("busy_set", 64'(busy), 64'd1);
            if (done) begin got = 1'b1; done_cyc = cyc; break; end
        end
        chk("done_seen", 64'(got), 64'd1);
        if (tot == 0) chk("zero_done_cyc", 64'(done_cyc), 64'd2);
        chk("done_cnt", 64'(done_cnt), 64'd1);
        chk("busy_at_done", 64'(busy), 64'd0);
        chk("error", 64'(error), 64'(exp_err));
        chk("run_count", 64'(run_addr_q.size()), 64'(exp_addr_q.size()));
        nchk = (run_addr_q.size() < exp_addr_q.size()) ? run_addr_q.size() : exp_addr_q.size();
        for (int i = 0; i < nchk; i++) begin
            chk("run_addr", 64'(run_addr_q[i]), 64'(exp_addr_q[i]));
            chk("run_len", 64'(run_len_q[i]), 64'(exp_len_q[i]));
        end
        chk("beats", 64'(beats_seen), 64'(exp_beats));
        @(negedge clk); #2;
        chk("done_pulse_end", 64'(done), 64'd0);
        chk("busy_after", 64'(busy), 64'd0);
        cli_en = 1'b0;
    endtask

    initial begin
        // reset state
        @(negedge clk); #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_run", 64'(run), 64'd0);
        chk("rst_len", 64'(length), 64'd0);
        chk("rst_saddr", 64'(s_addr), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_s_valid", 64'(s_valid), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 40 words from 0: three bursts 16/16/8
        xfer(32'h0, 40, -1, 1'b1);
        chk("r025_runs", 64'(run_addr_q.size()), 64'd3);
        if (run_addr_q.size() == 3) begin
            chk("r025_a1", 64'(run_addr_q[1]), 64'h40);
            chk("r025_a2", 64'(run_addr_q[2]), 64'h80);
            chk("r025_l0", 64'(run_len_q[0]), 64'd15);
            chk("r025_l2", 64'(run_len_q[2]), 64'd7);
        end

        // 4 KB boundary case
        xfer(32'h0000_0FF8, 4, -1, 1'b0);
`ifdef IOB2AXI_WR_BURST_4K_EN
        chk("r026_runs", 64'(run_addr_q.size()), 64'd2);
        if (run_addr_q.size() == 2) begin
            chk("r026_a1", 64'(run_addr_q[1]), 64'h1000);
            chk("r026_l1", 64'(run_len_q[1]), 64'd1);
        end
`else
        chk("r026_runs", 64'(run_addr_q.size()), 64'd1);
        if (run_addr_q.size() == 1) chk("r026_l0", 64'(run_len_q[0]), 64'd3);
`endif

        // zero-length transfer
        xfer(32'h0000_0100, 0, -1, 1'b0);

        // response error after first burst
        xfer(32'h0000_0200, 40, 0, 1'b0);
        cli_always = 1'b1;
        repeat (3) begin
            @(negedge clk); #2;
            chk("err_in_ready", 64'(in_ready), 64'd0);
            chk("err_sticky", 64'(error), 64'd1);
        end
        cli_always = 1'b0;

        // randomized transfers
        for (int t = 0; t < 8; t++) begin
            xfer({18'd0, 14'($urandom) & 14'h3FFC}, $urandom_range(1, 60),
                 ($urandom_range(0, 3) == 0) ? 1 : -1, 1'b0);
        end

        // reset during streaming
        prep(40, -1);
        @(negedge clk);
        start = 1'b1; base_addr = 32'h0000_0300; total = 16'd40;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk); #2;
            if (beats_seen >= 3) break;
        end
        chk("rst_mid_reached", 64'(beats_seen >= 3), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rmid_s_valid", 64'(s_valid), 64'd0);
        chk("rmid_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk); #2;
        chk("rmid_busy", 64'(busy), 64'd0);
        chk("rmid_done", 64'(done), 64'd0);
        chk("rmid_run", 64'(run), 64'd0);
        chk("rmid_len", 64'(length), 64'd0);
        chk("rmid_saddr", 64'(s_addr), 64'd0);
        chk("rmid_no_done", 64'(done_cnt), 64'd0);
        rst = 1'b0;
        cli_en = 1'b0;
        repeat (2) @(negedge clk);
        xfer(32'h0000_0040, 20, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iob2axi_wr_burst.md
IOB2AXI_WR_BURST -- requirements
Module: iob2axi_wr_burst

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; beat bytes B = DATA_W/8, a power of 2.
REQ-003 SHALL have parameter MAX_LEN, default 16, maximum beats per burst, range 1..256.
REQ-004 SHALL have parameter CNT_W, default 16, transfer word-count width.
REQ-005 SHALL have a single clock `clk` and reset `rst`; reset is asynchronous and active-high.
REQ-006 SHALL have these ports (name / direction / width / meaning):
- clk  in  1  clock
- rst  in  1  async active-high reset
- start  in  1  begin transfer
- base_addr  in  ADDR_W  start byte address, B-aligned
- total  in  CNT_W  words to write
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- error  out  1  sticky bresp error
- in_valid / in_wdata / in_wstrb  in  1 / DATA_W / B  client write stream
- in_ready  out  1  client beat accepted
- run  out  1  burst request to writer
- length  out  `AXI_LEN_W`  AXI len (beats-1)
- wr_ready  in  1  writer idle
- wr_error  in  1  writer response error
- s_valid  out  1  native valid
- s_addr  out  ADDR_W  native address
- s_wdata  out  DATA_W  native write data
- s_wstrb  out  B  native write strobes
- s_ready  in  1  writer beat accept

Function
REQ-007 SHALL implement states IDLE, ISSUE, STREAM, WAIT_B, FIN.
REQ-008 IDLE: on start, SHALL latch base_addr into addr and total into rem, set busy=1 and clear error; go to ISSUE, or to FIN if total==0 (no run issued).
REQ-009 start SHALL be ignored whenever busy=1.
REQ-010 ISSUE: SHALL compute burst beats N = min(rem, MAX_LEN[, 4K limit]) and drive s_addr=addr, length=N-1.
REQ-011 ISSUE: SHALL assert run for exactly one cycle, only when wr_ready=1, then go to STREAM; s_addr SHALL be valid in that same cycle.
REQ-012 STREAM: SHALL drive s_valid=in_valid, in_ready=s_ready, s_wdata=in_wdata, s_wstrb=in_wstrb combinationally; zero added latency.
REQ-013 STREAM: a beat SHALL count on s_valid&s_ready; on beat N, addr+=N*B and rem-=N, and the block SHALL go to WAIT_B.
REQ-014 Outside STREAM: s_valid=0 and in_ready=0.
REQ-015 WAIT_B: SHALL wait for wr_ready=1, then sample wr_error.
REQ-016 WAIT_B: if wr_error=1, SHALL set error=1 and go to FIN (abort; remaining client data not consumed).
REQ-017 WAIT_B: otherwise SHALL go to ISSUE if rem!=0, else to FIN.
REQ-018 FIN: SHALL pulse done=1 for one cycle, clear busy and return to IDLE; error SHALL hold until the next start.
REQ-019 addr arithmetic SHALL be modulo 2^ADDR_W; rem SHALL never underflow.
REQ-020 s_addr and length SHALL be stable from ISSUE through STREAM.

Reset
REQ-021 On rst: state=IDLE; run, s_valid, in_ready, busy, done, error = 0; length, s_addr, addr, rem = 0.
REQ-022 rst asserted mid-transfer SHALL abort immediately with no done pulse.

Configuration
REQ-023 With IOB2AXI_WR_BURST_4K_EN defined, N SHALL additionally be limited to (4096 - addr[11:0])/B so that no burst crosses a 4 KB boundary.
REQ-024 Without IOB2AXI_WR_BURST_4K_EN, N = min(rem, MAX_LEN) and the boundary logic SHALL be absent.

Verification
REQ-025 DATA_W=32, MAX_LEN=16, base 0x000, total 40 -> three runs: s_addr 0x000/0x040/0x080, length 15/15/7; 40 beats in order; done pulse; error=0.
REQ-026 4K_EN, base 0xFF8, total 4 -> runs at 0xFF8 len 1, then 0x1000 len 1; without the macro -> one run at 0xFF8 len 3.
REQ-027 total=0 -> no run, done pulse two cycles after start, busy low afterward.
REQ-028 wr_error=1 after the first of 3 bursts -> error=1, done pulse, no second run, in_ready stays 0.
REQ-029 in_valid toggling randomly and s_ready stalling -> beats counted only on handshake; data/strb passed unchanged; start pulsed while busy -> ignored.
REQ-030 rst asserted during STREAM -> all outputs zero next cycle; a new start afterward runs cleanly.
